// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo - buffered 8N1 UART transmitter.
//
// Bytes enter through a valid/ready port into a small FIFO. A frame FSM
// pops the FIFO head and serialises it LSB first: start bit (0), eight
// data bits, stop bit (1). Back-to-back frames have no idle gap.
//
// Ports:
//   wb_clk_i    in   1   clock, all state changes on the rising edge
//   wb_rst_i    in   1   synchronous active-high reset
//   in_data     in   8   byte to transmit
//   in_valid    in   1   in_data valid this cycle
//   in_ready    out  1   FIFO can accept a byte this cycle
//   tx          out  1   serial line, idles high, driven from a flop
//   busy        out  1   FIFO non-empty or frame in progress
//   fifo_count  out  W   bytes held in the FIFO (excludes the byte shifting)
//
// State  | meaning
// IDLE   | line high, waiting for a queued byte
// START  | start bit (tx=0)
// DATA   | data bits, LSB first
// STOP   | stop bit (tx=1); chains straight into START if more bytes wait
module uart_tx_fifo #(
    parameter int CLKS_PER_BIT = 4167,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic                          wb_clk_i,
    input  logic                          wb_rst_i,
    input  logic [7:0]                    in_data,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic                          tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int DW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [DW-1:0] DIV_LAST  = DW'(CLKS_PER_BIT - 1);
    localparam logic [AW:0]   DEPTH_CNT = (AW + 1)'(FIFO_DEPTH);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] START = 2'd1;
    localparam logic [1:0] DATA  = 2'd2;
    localparam logic [1:0] STOP  = 2'd3;

    logic [1:0]    state;
    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [DW-1:0] div;
    logic [2:0]    bit_cnt;
    logic [7:0]    shift;
    logic          push;
    logic          pop;
    logic          bit_done;
    logic          fifo_empty;

    assign in_ready   = (fifo_count != DEPTH_CNT);
    assign fifo_empty = (fifo_count == '0);
    assign push       = in_valid && in_ready;
    assign bit_done   = (div == DIV_LAST);
    // The head is taken either from idle or on the last stop-bit cycle,
    // which is what makes consecutive frames gapless.
    assign pop        = !fifo_empty && ((state == IDLE) || ((state == STOP) && bit_done));
    assign busy       = (state != IDLE) || !fifo_empty;

    // FIFO storage carries no reset; only pointers and count are cleared.
    always_ff @(posedge wb_clk_i) begin
        if (push) begin
            mem[wr_ptr] <= in_data;
        end
    end

    // Pointers wrap naturally because FIFO_DEPTH is a power of two.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state   <= IDLE;
            tx      <= 1'b1;
            div     <= '0;
            bit_cnt <= '0;
            shift   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    div <= '0;
                    if (pop) begin
                        state <= START;
                        shift <= mem[rd_ptr];
                        tx    <= 1'b0;
                    end
                end
                START: begin
                    if (bit_done) begin
                        div   <= '0;
                        state <= DATA;
                        tx    <= shift[0];
                    end else begin
                        div <= div + 1'b1;
                    end
                end
                DATA: begin
                    if (bit_done) begin
                        div <= '0;
                        if (bit_cnt == 3'd7) begin
                            bit_cnt <= '0;
                            state   <= STOP;
                            tx      <= 1'b1;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                            shift   <= shift >> 1;
                            // tx is registered, so it takes the bit that
                            // becomes shift[0] after this shift.
                            tx      <= shift[1];
                        end
                    end else begin
                        div <= div + 1'b1;
                    end
                end
                STOP: begin
                    if (bit_done) begin
                        div <= '0;
                        if (pop) begin
                            state <= START;
                            shift <= mem[rd_ptr];
                            tx    <= 1'b0;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        div <= div + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    tx    <= 1'b1;
                    div   <= '0;
                end
            endcase
        end
    end

endmodule
